// File: rtl/ar_req_arbiter_buffer.sv
// Multi-channel AXI AR request buffer: per-channel FIFOs, a QoS-aware round-robin
// arbiter, a registered AR master output and an outstanding-burst credit counter.
module ar_req_arbiter_buffer #(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned LEN_WIDTH       = 8,
  parameter int unsigned TAG_WIDTH       = 4,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [NUM_CH-1:0]                               in_valid,
  output logic [NUM_CH-1:0]                               in_ready,
  input  logic [NUM_CH*ID_WIDTH-1:0]                      in_id,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]                    in_addr,
  input  logic [NUM_CH*LEN_WIDTH-1:0]                     in_len,
  input  logic [NUM_CH*3-1:0]                             in_size,
  input  logic [NUM_CH*2-1:0]                             in_burst,
  input  logic [NUM_CH*4-1:0]                             in_qos,
  input  logic [NUM_CH*TAG_WIDTH-1:0]                     in_tagid,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [ID_WIDTH-1:0]                             out_id,
  output logic [ADDR_WIDTH-1:0]                           out_addr,
  output logic [LEN_WIDTH-1:0]                            out_len,
  output logic [2:0]                                      out_size,
  output logic [1:0]                                      out_burst,
  output logic [3:0]                                      out_qos,
  output logic [TAG_WIDTH-1:0]                            out_tagid,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  out_ch,
  input  logic                                            done,
  output logic [NUM_CH*($clog2(FIFO_DEPTH)+1)-1:0]        fill,
  output logic [$clog2(MAX_OUTSTANDING):0]                outstanding
);

  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned OUT_W     = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned TAG_LSB   = 0;
  localparam int unsigned QOS_LSB   = TAG_LSB + TAG_WIDTH;
  localparam int unsigned BURST_LSB = QOS_LSB + 4;
  localparam int unsigned SIZE_LSB  = BURST_LSB + 2;
  localparam int unsigned LEN_LSB   = SIZE_LSB + 3;
  localparam int unsigned ADDR_LSB  = LEN_LSB + LEN_WIDTH;
  localparam int unsigned ID_LSB    = ADDR_LSB + ADDR_WIDTH;
  localparam int unsigned PL_W      = ID_LSB + ID_WIDTH;

  logic [PL_W-1:0]  mem [NUM_CH][FIFO_DEPTH];
  logic [CNT_W-1:0] wr_ptr [NUM_CH];
  logic [CNT_W-1:0] rd_ptr [NUM_CH];
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [PL_W-1:0]  in_pl [NUM_CH];
  logic [PL_W-1:0]  head [NUM_CH];
  logic [3:0]       head_qos [NUM_CH];
  logic [NUM_CH-1:0] nonempty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  win;
  logic [CH_W-1:0]  idx;
  logic [3:0]       max_qos;
  logic             any_head;
  logic             found;
  logic             credit_ok;
  logic             issue;
  logic             dec;
  logic [PL_W-1:0]  win_pl;

  // Per-channel FIFO status, payload packing and head extraction
  always_comb begin
    in_ready = '0;
    nonempty = '0;
    push     = '0;
    pop      = '0;
    fill     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      in_pl[c] = {in_id[c*ID_WIDTH +: ID_WIDTH], in_addr[c*ADDR_WIDTH +: ADDR_WIDTH],
                  in_len[c*LEN_WIDTH +: LEN_WIDTH], in_size[c*3 +: 3], in_burst[c*2 +: 2],
                  in_qos[c*4 +: 4], in_tagid[c*TAG_WIDTH +: TAG_WIDTH]};
      // Full when the wrap bits differ but the index bits match
      in_ready[c] = !((wr_ptr[c][PTR_W] != rd_ptr[c][PTR_W]) &&
                      (wr_ptr[c][PTR_W-1:0] == rd_ptr[c][PTR_W-1:0]));
      nonempty[c] = (wr_ptr[c] != rd_ptr[c]);
      push[c]     = in_valid[c] && in_ready[c];
      pop[c]      = issue && (win == CH_W'(c));
      head[c]     = mem[c][rd_ptr[c][PTR_W-1:0]];
      head_qos[c] = head[c][QOS_LSB +: 4];
      fill[c*CNT_W +: CNT_W] = cnt[c];
    end
  end

  // Highest head QoS wins; ties resolved round-robin from rr_ptr upward
  always_comb begin
    max_qos  = '0;
    any_head = 1'b0;
    win      = '0;
    found    = 1'b0;
    idx      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (nonempty[c] && (!any_head || (head_qos[c] > max_qos))) begin
        max_qos  = head_qos[c];
        any_head = 1'b1;
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      idx = CH_W'((int'(rr_ptr) + k) % int'(NUM_CH));
      if (!found && nonempty[idx] && (head_qos[idx] == max_qos)) begin
        win   = idx;
        found = 1'b1;
      end
    end
    win_pl = head[win];
  end

  always_comb begin
    credit_ok = (outstanding < OUT_W'(MAX_OUTSTANDING)) ||
                ((outstanding == OUT_W'(MAX_OUTSTANDING)) && done);
    issue     = (!out_valid || out_ready) && any_head && credit_ok;
    dec       = done && (outstanding != '0);
  end

  // FIFO storage carries no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) mem[c][wr_ptr[c][PTR_W-1:0]] <= in_pl[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + CNT_W'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + CNT_W'(1);
        if (push[c] && !pop[c])      cnt[c] <= cnt[c] + CNT_W'(1);
        else if (pop[c] && !push[c]) cnt[c] <= cnt[c] - CNT_W'(1);
      end
    end
  end

  // AR output register: loads on issue, holds until handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_addr  <= '0;
      out_len   <= '0;
      out_size  <= '0;
      out_burst <= '0;
      out_qos   <= '0;
      out_tagid <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_id    <= win_pl[ID_LSB +: ID_WIDTH];
      out_addr  <= win_pl[ADDR_LSB +: ADDR_WIDTH];
      out_len   <= win_pl[LEN_LSB +: LEN_WIDTH];
      out_size  <= win_pl[SIZE_LSB +: 3];
      out_burst <= win_pl[BURST_LSB +: 2];
      out_qos   <= win_pl[QOS_LSB +: 4];
      out_tagid <= win_pl[TAG_LSB +: TAG_WIDTH];
      out_ch    <= win;
      rr_ptr    <= CH_W'((int'(win) + 1) % int'(NUM_CH));
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Credits are taken at issue time, so a held request already counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (issue && !dec) begin
      outstanding <= outstanding + OUT_W'(1);
    end else if (!issue && dec) begin
      outstanding <= outstanding - OUT_W'(1);
    end
  end

endmodule

// File: tb/tb_ar_req_arbiter_buffer.sv
// Randomized bench for ar_req_arbiter_buffer: queue-based reference model predicts
// issues into a scoreboard; a separate monitor checks every AR handshake.
module tb_ar_req_arbiter_buffer;

  localparam int NUM_CH      = 2;
  localparam int ID_WIDTH    = 4;
  localparam int ADDR_WIDTH  = 32;
  localparam int LEN_WIDTH   = 8;
  localparam int TAG_WIDTH   = 4;
  localparam int FIFO_DEPTH  = 16;
  localparam int MAX_OUT     = 8;
  localparam int CH_W        = 1;
  localparam int CNT_W       = 5;
  localparam int OUT_W       = 4;

  typedef struct {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [3:0]            qos;
    logic [TAG_WIDTH-1:0]  tag;
    int                    ch;
  } req_t;

  logic                          clk;
  logic                          rst_n;
  logic [NUM_CH-1:0]             in_valid;
  logic [NUM_CH-1:0]             in_ready;
  logic [NUM_CH*ID_WIDTH-1:0]    in_id;
  logic [NUM_CH*ADDR_WIDTH-1:0]  in_addr;
  logic [NUM_CH*LEN_WIDTH-1:0]   in_len;
  logic [NUM_CH*3-1:0]           in_size;
  logic [NUM_CH*2-1:0]           in_burst;
  logic [NUM_CH*4-1:0]           in_qos;
  logic [NUM_CH*TAG_WIDTH-1:0]   in_tagid;
  logic                          out_valid;
  logic                          out_ready;
  logic [ID_WIDTH-1:0]           out_id;
  logic [ADDR_WIDTH-1:0]         out_addr;
  logic [LEN_WIDTH-1:0]          out_len;
  logic [2:0]                    out_size;
  logic [1:0]                    out_burst;
  logic [3:0]                    out_qos;
  logic [TAG_WIDTH-1:0]          out_tagid;
  logic [CH_W-1:0]               out_ch;
  logic                          done;
  logic [NUM_CH*CNT_W-1:0]       fill;
  logic [OUT_W-1:0]              outstanding;

  ar_req_arbiter_buffer #(
    .NUM_CH(NUM_CH), .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH),
    .TAG_WIDTH(TAG_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_id(in_id), .in_addr(in_addr), .in_len(in_len), .in_size(in_size),
    .in_burst(in_burst), .in_qos(in_qos), .in_tagid(in_tagid),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_addr(out_addr),
    .out_len(out_len), .out_size(out_size), .out_burst(out_burst), .out_qos(out_qos),
    .out_tagid(out_tagid), .out_ch(out_ch), .done(done), .fill(fill),
    .outstanding(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  req_t qs [NUM_CH][$];
  req_t exp_q [$];
  req_t cand [NUM_CH];
  bit   m_valid;
  int   m_rr;
  int   m_outs;
  int   checks;
  int   failures;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) qs[c].delete();
    exp_q.delete();
    m_valid = 1'b0;
    m_rr    = 0;
    m_outs  = 0;
  endtask

  // One clock of the reference: pick a winner from queue heads, then accept pushes
  task automatic model_step(input logic [NUM_CH-1:0] v, input bit ordy, input bit dn);
    bit   rdy [NUM_CH];
    int   bq;
    int   best;
    int   i;
    bit   credit;
    bit   iss;
    req_t r;
    bq   = -1;
    best = -1;
    for (int c = 0; c < NUM_CH; c++) rdy[c] = (qs[c].size() < FIFO_DEPTH);
    for (int c = 0; c < NUM_CH; c++)
      if (qs[c].size() > 0 && int'(qs[c][0].qos) > bq) bq = int'(qs[c][0].qos);
    for (int k = 0; k < NUM_CH; k++) begin
      i = (m_rr + k) % NUM_CH;
      if (best < 0 && qs[i].size() > 0 && int'(qs[i][0].qos) == bq) best = i;
    end
    credit = (m_outs < MAX_OUT) || (m_outs == MAX_OUT && dn);
    iss = (!m_valid || ordy) && (best >= 0) && credit;
    if (iss) begin
      r = qs[best].pop_front();
      r.ch = best;
      exp_q.push_back(r);
      m_valid = 1'b1;
      m_rr = (best + 1) % NUM_CH;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    m_outs = m_outs + (iss ? 1 : 0) - ((dn && m_outs > 0) ? 1 : 0);
    for (int c = 0; c < NUM_CH; c++) begin
      if (v[c] && rdy[c]) begin
        r = cand[c];
        r.ch = c;
        qs[c].push_back(r);
      end
    end
  endtask

  task automatic cycle(input logic [NUM_CH-1:0] v, input bit ordy, input bit dn);
    @(negedge clk);
    in_valid  = v;
    out_ready = ordy;
    done      = dn;
    for (int c = 0; c < NUM_CH; c++) begin
      in_id[c*ID_WIDTH +: ID_WIDTH]       = cand[c].id;
      in_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = cand[c].addr;
      in_len[c*LEN_WIDTH +: LEN_WIDTH]    = cand[c].len;
      in_size[c*3 +: 3]                   = cand[c].size;
      in_burst[c*2 +: 2]                  = cand[c].burst;
      in_qos[c*4 +: 4]                    = cand[c].qos;
      in_tagid[c*TAG_WIDTH +: TAG_WIDTH]  = cand[c].tag;
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("outstanding", 64'(outstanding), 64'(m_outs));
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("fill%0d", c), 64'(fill[c*CNT_W +: CNT_W]), 64'(qs[c].size()));
      chk($sformatf("in_ready%0d", c), 64'(in_ready[c]), 64'(qs[c].size() < FIFO_DEPTH));
    end
    model_step(v, ordy, dn);
  endtask

  // mode: 0 all qos 0, 1 ch0=2/ch1=9, 2 full random, 3 narrow range (many ties)
  task automatic phase(input int n, input int ivp, input int orp, input int dnp,
                       input int mode, input logic [NUM_CH-1:0] mask);
    logic [NUM_CH-1:0] v;
    bit o;
    bit d;
    for (int j = 0; j < n; j++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cand[c].id    = ID_WIDTH'($urandom);
        cand[c].addr  = ADDR_WIDTH'($urandom);
        cand[c].len   = LEN_WIDTH'($urandom);
        cand[c].size  = 3'($urandom);
        cand[c].burst = 2'($urandom);
        cand[c].tag   = TAG_WIDTH'($urandom);
        case (mode)
          0:       cand[c].qos = 4'd0;
          1:       cand[c].qos = (c == 0) ? 4'd2 : 4'd9;
          2:       cand[c].qos = 4'($urandom_range(15, 0));
          default: cand[c].qos = 4'($urandom_range(3, 0));
        endcase
        v[c] = mask[c] && ($urandom_range(99, 0) < ivp);
      end
      o = ($urandom_range(99, 0) < orp);
      d = ($urandom_range(99, 0) < dnp);
      cycle(v, o, d);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    done      = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'({NUM_CH{1'b1}}));
    chk("rst_fill", 64'(fill), 64'(0));
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    chk("rst_out_addr", 64'(out_addr), 64'(0));
    chk("rst_out_ch", 64'(out_ch), 64'(0));
    model_reset();
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every handshake must match the oldest predicted issue
  initial begin : monitor
    req_t r;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL hs_unexpected actual=addr 0x%0h required=no handshake t=%0t", out_addr, $time);
        end else begin
          r = exp_q.pop_front();
          chk("hs_addr", 64'(out_addr), 64'(r.addr));
          chk("hs_ch", 64'(out_ch), 64'(r.ch));
          chk("hs_fields", 64'({out_id, out_len, out_size, out_burst, out_qos, out_tagid}),
              64'({r.id, r.len, r.size, r.burst, r.qos, r.tag}));
        end
      end
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    done      = 1'b0;
    in_id = '0; in_addr = '0; in_len = '0; in_size = '0;
    in_burst = '0; in_qos = '0; in_tagid = '0;
    for (int c = 0; c < NUM_CH; c++) cand[c] = '{default: 0};
    model_reset();
    do_reset();

    // Single ch0 push: out_valid two cycles later, one credit used
    cand[0].addr = 32'h1000;
    cand[0].len  = 8'd3;
    cand[0].qos  = 4'd0;
    cycle(2'b01, 1'b1, 1'b0);
    repeat (3) cycle(2'b00, 1'b1, 1'b0);

    // Equal-qos contention, fixed-qos priority, and round-robin with ties
    phase(40, 70, 100, 60, 0, 2'b11);
    phase(30, 90, 30, 50, 1, 2'b11);
    phase(30, 0, 100, 60, 1, 2'b11);

    // Backpressure until ch0 fills, then release
    do_reset();
    phase(20, 100, 0, 0, 2, 2'b01);
    phase(25, 0, 100, 0, 2, 2'b01);

    // Credit limit with no done, then single done pulses at the limit
    do_reset();
    phase(20, 80, 100, 0, 3, 2'b11);
    phase(3, 0, 100, 100, 3, 2'b11);
    phase(10, 0, 100, 0, 3, 2'b11);
    phase(40, 50, 100, 40, 3, 2'b11);

    // Random mixes, including a reset with traffic in flight
    for (int p = 0; p < 8; p++)
      phase(50, $urandom_range(100, 20), $urandom_range(100, 10), $urandom_range(80, 5),
            $urandom_range(3, 0), 2'($urandom_range(3, 1)));
    do_reset();
    phase(60, 60, 70, 50, 2, 2'b11);
    phase(60, 0, 100, 100, 2, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
